// File: rtl/matvec3_host_if.sv
// rtl/matvec3_host_if.sv - operand source and result sink streams between host and matvec3
//
// Purpose: bundles both valid/ready handshakes that connect matvec3_host to matvec3.
// Ports (signals):
//   m_valid, m_ready, m_data : operand stream, host -> matvec3
//   s_valid, s_ready, s_data : result stream, matvec3 -> host
// Modports: master = host side, slave = matvec3 side.
interface matvec3_host_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 28
);
  logic                    m_valid;
  logic                    m_ready;
  logic signed [IN_W-1:0]  m_data;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [OUT_W-1:0] s_data;

  modport master (
    output m_valid, m_data, s_ready,
    input  m_ready, s_valid, s_data
  );

  modport slave (
    input  m_valid, m_data, s_ready,
    output m_ready, s_valid, s_data
  );
endinterface

// File: rtl/matvec3_host.sv
// rtl/matvec3_host.sv - master-side driver for the 3x3 matrix-vector unit
//
// Purpose: holds a 12-entry operand buffer (W row-major at 0..8, x at 9..11),
// streams it to matvec3 on start, then collects the three y results.
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   load_en/addr/data    local buffer write port (IDLE only, addr 12..15 ignored)
//   start                begin a transaction (IDLE only)
//   busy, done           status; done is a one-cycle pulse in DONE
//   res_addr, res_data   combinational result read (addr 3 reads 0)
//   proto_err            sticky: s_valid seen outside RECV
//   mv                   operand/result streams to matvec3 (master modport)
module matvec3_host #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [3:0]              load_addr,
  input  logic signed [IN_W-1:0]  load_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [1:0]              res_addr,
  output logic signed [OUT_W-1:0] res_data,
  output logic                    proto_err,
  matvec3_host_if.master          mv
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RECV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]              state;
  logic [3:0]              idx;
  logic [1:0]              rcnt;
  logic signed [IN_W-1:0]  buf_q [12];
  logic signed [OUT_W-1:0] res_q [3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rcnt      <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < 12; i++) buf_q[i] <= '0;
      for (int i = 0; i < 3; i++)  res_q[i] <= '0;
    end else begin
      // Any result beat offered outside RECV means matvec3 and host disagree on phase.
      if (mv.s_valid && state != RECV) proto_err <= 1'b1;

      case (state)
        IDLE: begin
          // A load in the same cycle as start lands on this edge, so SEND sees it.
          if (load_en && load_addr < 4'd12) buf_q[load_addr] <= load_data;
          if (start) begin
            idx   <= '0;
            rcnt  <= '0;
            for (int i = 0; i < 3; i++) res_q[i] <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (mv.m_ready) begin
            idx <= idx + 4'd1;
            if (idx == 4'd11) state <= RECV;
          end
        end
        RECV: begin
          if (mv.s_valid) begin
            res_q[rcnt] <= mv.s_data;
            rcnt        <= rcnt + 2'd1;
            if (rcnt == 2'd2) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign mv.m_valid = (state == SEND);
  assign mv.m_data  = (state == SEND) ? buf_q[idx] : '0;
  assign mv.s_ready = (state == RECV);
  assign res_data   = (res_addr == 2'd3) ? '0 : res_q[res_addr];

endmodule

// File: tb/tb_matvec3_host.sv
// tb/tb_matvec3_host.sv - self-checking bench for matvec3_host
module tb_matvec3_host;

  logic              clk;
  logic              reset;
  logic              load_en;
  logic [3:0]        load_addr;
  logic signed [13:0] load_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [1:0]        res_addr;
  logic signed [27:0] res_data;
  logic              proto_err;

  matvec3_host_if #(.IN_W(14), .OUT_W(28)) bus ();

  matvec3_host #(.IN_W(14), .OUT_W(28)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .proto_err (proto_err),
    .mv        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int done_cnt;
  int stall_err;
  logic signed [13:0] wv   [12];
  logic signed [13:0] cap  [12];
  logic signed [27:0] gold [3];
  logic signed [27:0] exp_r[3];
  logic [3:0] pat;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = wv[i];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic compute_gold();
    for (int i = 0; i < 3; i++) begin
      int acc;
      acc = 0;
      for (int j = 0; j < 3; j++) acc += int'(wv[i*3+j]) * int'(wv[9+j]);
      gold[i] = 28'(acc);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Plays matvec3: accepts 12 operands (optionally stalling), returns gold as results.
  task automatic run_txn(input bit stall, input bit poke, output bit tmo);
    int sent, cyc, k;
    logic signed [13:0] prev;
    bit prev_st;
    sent = 0; cyc = 0; prev_st = 0; prev = '0; tmo = 0; stall_err = 0;
    while (sent < 12 && cyc < 300) begin
      bus.m_ready = stall ? pat[cyc % 4] : 1'b1;
      if (poke && cyc == 3) begin
        load_en = 1'b1; load_addr = 4'd0; load_data = 14'sd999; start = 1'b1;
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      #1;
      if (prev_st && bus.m_data !== prev) stall_err++;
      if (bus.m_valid && bus.m_ready) begin cap[sent] = bus.m_data; sent++; end
      prev_st = bus.m_valid && !bus.m_ready;
      prev    = bus.m_data;
      cyc++;
      @(negedge clk);
    end
    bus.m_ready = 1'b0; load_en = 1'b0; start = 1'b0;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 300) begin
      if (bus.s_ready) begin bus.s_valid = 1'b1; bus.s_data = gold[k]; k++; end
      else bus.s_valid = 1'b0;
      cyc++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    if (sent != 12 || k != 3) tmo = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 3; i++) begin
      res_addr = 2'(i); #1;
      checks++;
      if (res_data !== exp_r[i]) begin
        errors++;
        $display("FAIL %s res[%0d] got %0d want %0d", tag, i, res_data, exp_r[i]);
      end
    end
  endtask

  task automatic check_sent(input string tag);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (cap[i] !== wv[i]) begin
        errors++;
        $display("FAIL %s operand[%0d] got %0d want %0d", tag, i, cap[i], wv[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset m_valid got %b want 0", bus.m_valid); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset s_ready got %b want 0", bus.s_ready); end
    checks++; if (bus.m_data !== 14'sd0) begin errors++; $display("FAIL reset m_data got %0d want 0", bus.m_data); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset proto_err got %b want 0", proto_err); end
    exp_r[0] = '0; exp_r[1] = '0; exp_r[2] = '0;
    check_results("reset");
  endtask

  task automatic test_identity();
    bit tmo;
    wv = '{14'sd1, 14'sd0, 14'sd0, 14'sd0, 14'sd1, 14'sd0, 14'sd0, 14'sd0, 14'sd1,
           14'sd5, -14'sd7, 14'sd8191};
    load_range(0, 11);
    compute_gold();
    done_cnt = 0;
    start_pulse();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL identity busy_after_start got %b want 1", busy); end
    run_txn(0, 0, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL identity timeout got %b want 0", tmo); end
    check_sent("identity");
    exp_r[0] = 28'(5); exp_r[1] = 28'(-7); exp_r[2] = 28'(8191);
    check_results("identity");
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL identity done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL identity busy_end got %b want 0", busy); end
    res_addr = 2'd3; #1;
    checks++; if (res_data !== 28'sd0) begin errors++; $display("FAIL identity res_addr3 got %0d want 0", res_data); end
  endtask

  task automatic test_min_neg();
    bit tmo;
    for (int i = 0; i < 12; i++) wv[i] = -14'sd8192;
    load_range(0, 11);
    compute_gold();
    start_pulse();
    run_txn(0, 0, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL min_neg timeout got %b want 0", tmo); end
    exp_r[0] = 28'(201326592); exp_r[1] = 28'(201326592); exp_r[2] = 28'(201326592);
    check_results("min_neg");
  endtask

  task automatic test_stall();
    bit tmo;
    wv = '{14'sd1, 14'sd2, 14'sd3, 14'sd4, 14'sd5, 14'sd6, 14'sd7, 14'sd8, 14'sd9,
           14'sd1, -14'sd1, 14'sd2};
    load_range(0, 11);
    compute_gold();
    start_pulse();
    run_txn(1, 0, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall timeout got %b want 0", tmo); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall m_data_changed got %0d want 0", stall_err); end
    check_sent("stall");
    exp_r[0] = 28'(5); exp_r[1] = 28'(11); exp_r[2] = 28'(17);
    check_results("stall");
  endtask

  task automatic test_proto_err();
    bit tmo;
    start_pulse();
    bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = 28'sd291;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL proto s_ready_in_send got %b want 0", bus.s_ready); end
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto proto_err got %b want 1", proto_err); end
    exp_r[0] = '0; exp_r[1] = '0; exp_r[2] = '0;
    check_results("proto_nowrite");
    run_txn(0, 0, tmo);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto sticky got %b want 1", proto_err); end
    exp_r[0] = 28'(5); exp_r[1] = 28'(11); exp_r[2] = 28'(17);
    check_results("proto_after");
  endtask

  task automatic test_busy_ignore();
    bit tmo;
    done_cnt = 0;
    start_pulse();
    run_txn(0, 1, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL busy_ign timeout got %b want 0", tmo); end
    check_sent("busy_ign");
    check_results("busy_ign");
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_ign done_pulses got %0d want 1", done_cnt); end
    start_pulse();
    run_txn(0, 0, tmo);
    check_sent("busy_ign_rerun");
    check_results("busy_ign_rerun");
  endtask

  task automatic test_mid_reset();
    bit tmo;
    int sent, cyc;
    load_range(0, 11);
    start_pulse();
    sent = 0; cyc = 0;
    while (sent < 5 && cyc < 50) begin
      bus.m_ready = 1'b1; #1;
      if (bus.m_valid) sent++;
      cyc++;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst busy_before got %b want 1", busy); end
    reset = 1'b1; #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midrst m_valid got %b want 0", bus.m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %b want 0", busy); end
    checks++; if (bus.m_data !== 14'sd0) begin errors++; $display("FAIL midrst m_data got %0d want 0", bus.m_data); end
    bus.m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wv = '{14'sd2, 14'sd0, 14'sd0, 14'sd0, 14'sd3, 14'sd0, 14'sd0, 14'sd0, -14'sd1,
           14'sd10, 14'sd20, -14'sd4};
    load_range(0, 10);
    compute_gold();
    // last operand written in the same cycle as start
    load_en = 1'b1; load_addr = 4'd11; load_data = wv[11]; start = 1'b1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    run_txn(0, 0, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL midrst timeout got %b want 0", tmo); end
    check_sent("midrst");
    exp_r[0] = 28'(20); exp_r[1] = 28'(60); exp_r[2] = 28'(4);
    check_results("midrst");
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; stall_err = 0;
    pat = 4'b1001;
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; res_addr = '0;
    bus.m_ready = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_min_neg();
    test_stall();
    test_proto_err();
    do_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto cleared_by_reset got %b want 0", proto_err); end
    load_range(0, 11);
    test_busy_ignore();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
